// File: rtl/sys_defs.sv
// Shared definitions for the 4:2:0 chroma downsampler.
//   - Channel codes carried on ch_in / ch_out.
//   - Pixel block / quadrant container types, indexed [row][col][bit].
//   - quad_t: quadrant counter, doubles as the group FSM state.
package sys_defs;

    localparam int unsigned CH_W = 2;

    localparam logic [CH_W-1:0] CH_Y   = 2'd0;
    localparam logic [CH_W-1:0] CH_CB  = 2'd1;
    localparam logic [CH_W-1:0] CH_CR  = 2'd2;
    localparam logic [CH_W-1:0] CH_BAD = 2'd3;

    typedef logic [7:0][7:0][7:0] pix_block_t;
    typedef logic [3:0][3:0][7:0] pix_quad_t;

    // Quadrant about to be filled: TL, TR, BL, BR. Bit 1 = row half, bit 0 = col half.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    function automatic logic is_chroma(input logic [CH_W-1:0] ch);
        return (ch == CH_CB) || (ch == CH_CR);
    endfunction

endpackage

// File: rtl/avg2x2_8to4.sv
// 2x2 box-filter decimator: 8x8 block in, 4x4 averaged quadrant out.
// Purely combinational.
//   i_block : 8x8 input block, [row][col]
//   o_quad  : 4x4 result, o_quad[r][c] = mean of i_block rows 2r..2r+1, cols 2c..2c+1
// ROUND = 1 adds 2 before the divide by 4 (round half up); 0 truncates.
module avg2x2_8to4
    import sys_defs::*;
#(
    parameter bit ROUND = 1'b1
) (
    input  pix_block_t i_block,
    output pix_quad_t  o_quad
);

    localparam logic [9:0] RndBias = ROUND ? 10'd2 : 10'd0;

    always_comb begin : avg
        logic [9:0] w_sum;
        w_sum  = '0;
        o_quad = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                // Four 8-bit pixels plus bias never exceed 10 bits, so >>2 fits 8 bits.
                w_sum = {2'b00, i_block[2*r][2*c]}
                      + {2'b00, i_block[2*r][2*c+1]}
                      + {2'b00, i_block[2*r+1][2*c]}
                      + {2'b00, i_block[2*r+1][2*c+1]}
                      + RndBias;
                o_quad[r][c] = w_sum[9:2];
            end
        end
    end

endmodule

// File: rtl/chroma_downsample_4to1.sv
// 4:4:4 -> 4:2:0 block converter.
// Y blocks pass straight through; every four consecutive Cb (or Cr) blocks,
// arriving TL, TR, BL, BR, are 2x2-averaged into one 8x8 chroma block.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   valid_in, in_ready  : input handshake (transfer when both high)
//   ch_in, block_in     : channel (0=Y, 1=Cb, 2=Cr, 3=illegal) and 8x8 block
//   valid_out, out_ready: output handshake
//   ch_out, block_out   : registered output channel and block
//   err_out             : one-cycle pulse after an illegal channel or group mismatch
module chroma_downsample_4to1
    import sys_defs::*;
#(
    parameter bit ROUND = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [CH_W-1:0]        ch_in,
    input  logic [7:0][7:0][7:0]   block_in,
    output logic                   in_ready,
    output logic [7:0][7:0][7:0]   block_out,
    output logic [CH_W-1:0]        ch_out,
    output logic                   valid_out,
    input  logic                   out_ready,
    output logic                   err_out
);

    quad_t           r_quad,      w_quad_nxt;
    logic [CH_W-1:0] r_grp_ch,    w_grp_nxt;
    pix_block_t      r_acc,       w_acc_nxt;
    pix_block_t      r_block_out, w_blk_nxt;
    logic [CH_W-1:0] r_ch_out,    w_ch_nxt;
    logic            r_valid_out, w_valid_nxt;
    logic            r_err,       w_err_nxt;

    logic            w_xfer;
    logic            w_mismatch;
    logic            w_produce;
    quad_t           w_slot;
    pix_quad_t       w_avg;

    avg2x2_8to4 #(
        .ROUND (ROUND)
    ) u_avg (
        .i_block (block_in),
        .o_quad  (w_avg)
    );

    assign in_ready = !r_valid_out || out_ready;
    assign w_xfer   = valid_in && in_ready;

    // A chroma block of the other chroma channel mid-group restarts the group.
    assign w_mismatch = is_chroma(ch_in) && (r_quad != Q0) && (ch_in != r_grp_ch);
    assign w_slot     = w_mismatch ? Q0 : r_quad;

    always_comb begin
        w_quad_nxt = r_quad;
        w_grp_nxt  = r_grp_ch;
        w_acc_nxt  = r_acc;
        w_blk_nxt  = r_block_out;
        w_ch_nxt   = r_ch_out;
        w_produce  = 1'b0;
        w_err_nxt  = 1'b0;

        if (w_xfer) begin
            if (ch_in == CH_Y) begin
                w_produce = 1'b1;
                w_blk_nxt = block_in;
                w_ch_nxt  = CH_Y;
            end else if (is_chroma(ch_in)) begin
                w_err_nxt = w_mismatch;
                if (w_slot == Q0) begin
                    w_grp_nxt = ch_in;
                end
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        w_acc_nxt[{w_slot[1], 2'(r)}][{w_slot[0], 2'(c)}] = w_avg[r][c];
                    end
                end
                unique case (w_slot)
                    Q0: w_quad_nxt = Q1;
                    Q1: w_quad_nxt = Q2;
                    Q2: w_quad_nxt = Q3;
                    Q3: begin
                        // BR quadrant is merged from block_in this cycle, not from r_acc.
                        w_quad_nxt = Q0;
                        w_produce  = 1'b1;
                        w_blk_nxt  = w_acc_nxt;
                        w_ch_nxt   = r_grp_ch;
                    end
                endcase
            end else begin
                // Illegal channel: accepted and dropped.
                w_err_nxt = 1'b1;
            end
        end

        w_valid_nxt = w_produce || (r_valid_out && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quad      <= Q0;
            r_grp_ch    <= '0;
            r_acc       <= '0;
            r_block_out <= '0;
            r_ch_out    <= '0;
            r_valid_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_quad      <= w_quad_nxt;
            r_grp_ch    <= w_grp_nxt;
            r_acc       <= w_acc_nxt;
            r_block_out <= w_blk_nxt;
            r_ch_out    <= w_ch_nxt;
            r_valid_out <= w_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign block_out = r_block_out;
    assign ch_out    = r_ch_out;
    assign valid_out = r_valid_out;
    assign err_out   = r_err;

endmodule

// File: doc/chroma_downsample_4to1.md
Name: chroma_downsample_4to1

Overview:
Encoder-side counterpart of the chroma supersampler: consumes full-resolution 8x8 pixel blocks per channel and emits 4:2:0 data. Y blocks pass through unchanged. Each run of four consecutive Cb (or Cr) blocks, covering one 16x16 region, is reduced by 2x2 averaging to a single 8x8 chroma block. Sits between colour conversion and the forward DCT, with valid/ready handshaking on both sides.

Parameters:
ROUND, 1, 1 = round-half-up averaging (+2 before >>2); 0 = truncate.

Ports:
clk  input  1  clock; the only clock.
rst  input  1  reset, synchronous, active-high.
valid_in  input  1  input block valid; a transfer occurs when valid_in && in_ready.
ch_in  input  $clog2(`CH+1)  channel: 0=Y, 1=Cb, 2=Cr; 3 is illegal.
block_in  input  8 x [7:0][7:0]  input pixel block, [row][col].
in_ready  output  1  block can accept an input transfer.
block_out  output  8 x [7:0][7:0]  output block, registered.
ch_out  output  $clog2(`CH+1)  channel of block_out.
valid_out  output  1  block_out holds an unconsumed block.
out_ready  input  1  downstream accepts the output when valid_out && out_ready.
err_out  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset: block_out = 0, ch_out = 0, valid_out = 0, err_out = 0, quad_cnt = 0, grp_ch = 0, accumulator = 0. Reset mid-group discards the partial group.
- in_ready = !valid_out || out_ready. This is combinational and full-throughput.
- Output register: valid_out is set when a result is produced. It is cleared on out_ready when no new result is produced in the same cycle. A simultaneous consume and produce keeps valid_out = 1 and loads the new data.
- Y transfer: next cycle block_out = block_in, ch_out = 0, valid_out = 1 (latency 1). Chroma state (quad_cnt, grp_ch, accumulator) is untouched, so Y may interleave with a chroma group.
- Chroma transfer, quadrant q = quad_cnt:
  - Quadrant placement: q=0 TL, q=1 TR, q=2 BL, q=3 BR, giving qr = q[1], qc = q[0].
  - Averaging: for r,c in 0..3, acc[4*qr+r][4*qc+c] = (in[2r][2c] + in[2r][2c+1] + in[2r+1][2c] + in[2r+1][2c+1] + (ROUND ? 2 : 0)) >> 2.
  - Use a 10-bit sum; the result fits 8 bits with no saturation required.
  - q=0: grp_ch <= ch_in.
  - q<3: write the quadrant into acc; quad_cnt++; no output.
  - q=3: block_out = acc with the BR quadrant merged from the current block_in in the same cycle; ch_out = grp_ch; valid_out = 1; quad_cnt wraps to 0. Latency is 1 cycle after the 4th transfer.
- Channel mismatch: a chroma ch_in != grp_ch while quad_cnt != 0 triggers the following:
  - err_out pulses.
  - The partial group is discarded.
  - The incoming block is taken as q=0 of a new group (quad_cnt = 1, grp_ch = ch_in).
- Illegal ch_in = 3: the transfer is accepted and dropped, err_out pulses, and state is unchanged.
- valid_in while !in_ready: no transfer and no state change. The upstream must hold its inputs.
- FSM encoded by quad_cnt: Q0 -> Q1 -> Q2 -> Q3 -> Q0. Transitions occur only on chroma transfers. Mismatch goes to Q1, rst goes to Q0.

Decomposition:
- Shared package (sys_defs):
  - channel constants CH_Y = 0, CH_CB = 1, CH_CR = 2.
  - typedef pix_block_t for [7:0][7:0] of 8-bit.
  - typedef quad_t (2-bit).
- Sub-module: avg2x2_8to4. Combinational; maps an 8x8 block to a 4x4 averaged quadrant; takes ROUND.
- Top module: instantiates avg2x2_8to4 once and handles the FSM, accumulator and output register.

Test Plan:
- Y passthrough: one Y block with pixel = 8r+c and out_ready = 1 -> next cycle valid_out = 1, ch_out = 0, block_out identical; valid_out = 0 the cycle after.
- Flat chroma: four Cb blocks of constant values 10, 20, 30, 40 -> one output with ch_out = 1 and quadrants TL = 10, TR = 20, BL = 30, BR = 40; valid_out asserts only after the 4th transfer.
- Rounding: 2x2 patch {1,2,2,2} -> output 2 with ROUND = 1 and 1 with ROUND = 0; an all-255 block gives 255 with no overflow.
- Interleave and backpressure:
  - Sequence: Cr q0, Y, Cr q1..q3 with out_ready = 0 after the Y output.
  - Expected: in_ready = 0 while the Y result is held and no input is lost.
  - Once out_ready = 1, the Y block emerges, then the Cr block with ch_out = 2.
- Errors:
  - Cb, Cb, then Cr -> err_out pulse, and the Cr becomes q0.
  - ch_in = 3 -> err_out pulse with no state change.
- Reset: assert rst after 2 Cb blocks -> all outputs 0; the next 4 Cb blocks form a correct fresh group.
